// File: rtl/seq_slice_adder.sv
// -----------------------------------------------------------------------------
// seq_slice_adder
//   Multi-cycle unsigned add/subtract for mantissa datapaths. A WIDTH-bit
//   operation is split into NSLICE = WIDTH/SLICE chunks, one chunk per clock,
//   with a carry register between chunks, so the carry chain is SLICE bits.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous reset, active low
//   in_valid   in   operands valid
//   in_ready   out  unit accepts operands this cycle (combinational)
//   a, b       in   WIDTH-bit unsigned operands
//   sub        in   0: s = a + b, 1: s = a - b (sampled with operands)
//   out_valid  out  result valid (registered)
//   out_ready  in   consumer takes the result
//   s          out  WIDTH-bit result modulo 2^WIDTH (registered)
//   cout       out  add: carry out; sub: 1 = no borrow (a >= b) (registered)
// -----------------------------------------------------------------------------
module seq_slice_adder #(
    parameter int WIDTH = 24,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    // Refuse to elaborate when the operand does not split evenly into slices.
    generate
        if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_slice
            $error("seq_slice_adder: WIDTH must be an integer multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [KW-1:0]    k_r;
    logic             carry_r;
    // Operand registers shift right one slice per RUN cycle, so the active
    // slice is always in the low SLICE bits.
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] s_r;
    logic             cout_r;
    logic             out_valid_r;

    logic             accept_s;
    logic [SLICE:0]   slice_sum_s;

    assign in_ready  = (state_r == ST_IDLE) | ((state_r == ST_DONE) & out_ready);
    assign accept_s  = in_valid & in_ready;
    assign s         = s_r;
    assign cout      = cout_r;
    assign out_valid = out_valid_r;

    // One slice of the addition: low slice of each operand plus the carry.
    always_comb begin
        slice_sum_s = {1'b0, a_r[SLICE-1:0]} + {1'b0, b_r[SLICE-1:0]}
                    + {{SLICE{1'b0}}, carry_r};
    end

    // Control FSM with operand, carry and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            k_r         <= {KW{1'b0}};
            carry_r     <= 1'b0;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            s_r         <= {WIDTH{1'b0}};
            cout_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_r     <= a;
                        // Subtraction is a + ~b + 1; the +1 enters as carry-in.
                        b_r     <= sub ? ~b : b;
                        carry_r <= sub;
                        k_r     <= {KW{1'b0}};
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    for (int j = 0; j < NSLICE; j++) begin
                        if (k_r == KW'(j)) begin
                            s_r[j*SLICE +: SLICE] <= slice_sum_s[SLICE-1:0];
                        end
                    end
                    carry_r <= slice_sum_s[SLICE];
                    a_r     <= a_r >> SLICE;
                    b_r     <= b_r >> SLICE;
                    k_r     <= k_r + KW'(1);
                    if (k_r == K_LAST) begin
                        cout_r      <= slice_sum_s[SLICE];
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end

                ST_DONE: begin
                    if (accept_s) begin
                        // Back-to-back: result consumed and next operands
                        // captured on the same edge.
                        a_r         <= a;
                        b_r         <= sub ? ~b : b;
                        carry_r     <= sub;
                        k_r         <= {KW{1'b0}};
                        out_valid_r <= 1'b0;
                        state_r     <= ST_RUN;
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end

                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_slice_adder.sv
module tb_seq_slice_adder;

    logic        clk;
    logic        rst_n;

    // DUT 1: WIDTH=24, SLICE=8
    logic        in_valid;
    logic        in_ready;
    logic [23:0] a;
    logic [23:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] s;
    logic        cout;

    // DUT 2: WIDTH=24, SLICE=24
    logic        in_valid2;
    logic        in_ready2;
    logic [23:0] a2;
    logic [23:0] b2;
    logic        sub2;
    logic        out_valid2;
    logic        out_ready2;
    logic [23:0] s2;
    logic        cout2;

    int check_cnt;
    int error_cnt;

    seq_slice_adder #(.WIDTH(24), .SLICE(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout)
    );

    seq_slice_adder #(.WIDTH(24), .SLICE(24)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .sub(sub2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .s(s2), .cout(cout2)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            error_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation on DUT 1, check latency and result, then consume it.
    task automatic run_op(input string tag, input logic [23:0] op_a, input logic [23:0] op_b,
                          input logic op_sub, input logic [23:0] exp_s, input logic exp_cout);
        int cnt;
        in_valid  = 1'b1;
        a         = op_a;
        b         = op_b;
        sub       = op_sub;
        out_ready = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        a        = 24'hA5A5A5;
        b        = 24'h5A5A5A;
        sub      = ~op_sub;
        cnt      = 0;
        while (!out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        check({tag, "_latency"}, 32'(cnt), 32'd3);
        check({tag, "_s"}, 32'(s), 32'(exp_s));
        check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
        tick();
    endtask

    initial begin
        int cnt;
        int seen;
        check_cnt  = 0;
        error_cnt  = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        a          = 24'h000000;
        b          = 24'h000000;
        sub        = 1'b0;
        out_ready  = 1'b1;
        in_valid2  = 1'b0;
        a2         = 24'h000000;
        b2         = 24'h000000;
        sub2       = 1'b0;
        out_ready2 = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_s", 32'(s), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);

        // Directed arithmetic vectors
        run_op("add_carry_chain", 24'h00FFFF, 24'h000001, 1'b0, 24'h010000, 1'b0);
        run_op("add_wrap",        24'hFFFFFF, 24'h000001, 1'b0, 24'h000000, 1'b1);
        run_op("add_msb",         24'h800000, 24'h800000, 1'b0, 24'h000000, 1'b1);
        run_op("sub_borrow",      24'h000005, 24'h000007, 1'b1, 24'hFFFFFE, 1'b0);
        run_op("sub_equal",       24'h800000, 24'h800000, 1'b1, 24'h000000, 1'b1);
        run_op("sub_nob",         24'h123456, 24'h000056, 1'b1, 24'h123400, 1'b1);

        // Backpressure: result held while consumer stalls
        in_valid  = 1'b1;
        a         = 24'h000001;
        b         = 24'h000002;
        sub       = 1'b0;
        out_ready = 1'b0;
        tick();
        a   = 24'h000100;
        b   = 24'h000200;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        check("bp_latency", 32'(cnt), 32'd3);
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_s", 32'(s), 32'h000003);
            check("bp_cout", 32'(cout), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_release", 32'(in_ready), 32'd1);
        tick();
        check("bp_accept_out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        a        = 24'hFFFFFF;
        b        = 24'hFFFFFF;
        cnt      = 0;
        while (!out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        check("bp2_latency", 32'(cnt), 32'd3);
        check("bp2_s", 32'(s), 32'h000300);
        check("bp2_cout", 32'(cout), 32'd0);
        tick();

        // Reset in the middle of RUN (k=1)
        in_valid = 1'b1;
        a        = 24'h111111;
        b        = 24'h222222;
        sub      = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_s", 32'(s), 32'd0);
        check("mid_rst_cout", 32'(cout), 32'd0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid) seen = 1;
        end
        check("mid_rst_no_pulse", 32'(seen), 32'd0);
        run_op("post_rst_add", 24'h000010, 24'h000020, 1'b0, 24'h000030, 1'b0);

        // Single-slice instance
        in_valid2 = 1'b1;
        a2        = 24'hFFFFFF;
        b2        = 24'h000002;
        sub2      = 1'b0;
        check("w24_in_ready", 32'(in_ready2), 32'd1);
        tick();
        in_valid2 = 1'b0;
        cnt       = 0;
        while (!out_valid2 && cnt < 20) begin
            tick();
            cnt++;
        end
        check("w24_latency", 32'(cnt), 32'd1);
        check("w24_s", 32'(s2), 32'h000001);
        check("w24_cout", 32'(cout2), 32'd1);
        tick();
        check("w24_consumed", 32'(out_valid2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

endmodule
